// File: rtl/mul_pipe.sv
// mul_pipe: pipelined radix-4 Booth multiplier with multiply-accumulate.
// Booth partial products are reduced in carry-save form; a single
// carry-propagate add at the end folds in +acc (madd), ~acc (msub, with the
// result complemented) or nothing (mul). Valid bits travel in a shift
// register that advances whenever the output is not stalled.
module mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic               mul_clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [2*WIDTH-1:0] in_acc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int PW  = 2*WIDTH;
  localparam int NPP = WIDTH/2 + 1;

  typedef logic [NPP-1:0][PW-1:0] pp_t;

  // Stage-1 payload: shifted partial products, Booth +1 carries, addend.
  typedef struct packed {
    pp_t              pp;
    logic [PW-1:0]    cy;
    logic [PW-1:0]    addend;
    logic             inv;
    logic [TAG_W-1:0] tag;
  } s1_t;

  // Post-reduction payload: carry-save pair plus addend.
  typedef struct packed {
    logic [PW-1:0]    s;
    logic [PW-1:0]    c;
    logic [PW-1:0]    addend;
    logic             inv;
    logic [TAG_W-1:0] tag;
  } cs_t;

  // Carry-save reduction of all partial-product rows down to a sum/carry
  // pair. Carries out of the top bit are dropped: the result is mod 2^PW.
  function automatic cs_t reduce(input s1_t a);
    cs_t           r;
    logic [PW-1:0] t;
    r.s = a.cy;
    r.c = '0;
    for (int i = 0; i < NPP; i++) begin
      t   = r.s ^ r.c ^ a.pp[i];
      r.c = ((r.s & r.c) | (r.s & a.pp[i]) | (r.c & a.pp[i])) << 1;
      r.s = t;
    end
    r.addend = a.addend;
    r.inv    = a.inv;
    r.tag    = a.tag;
    return r;
  endfunction

  logic [STAGES:1]  vld_pipe_q;
  logic             adv;
  logic [PW-1:0]    x_ext;
  logic [WIDTH+2:0] y_ext;
  logic [2:0]       trip;
  logic [PW-1:0]    mag;
  logic             neg;
  s1_t              front;
  cs_t              fin;
  logic [PW-1:0]    res_d;
  logic [PW-1:0]    result_q;
  logic [TAG_W-1:0] tag_q;

  // Everything advances unless a valid result is waiting on the consumer.
  assign out_valid  = vld_pipe_q[STAGES];
  assign adv        = ~(out_valid & ~out_ready);
  assign in_ready   = adv;
  assign out_result = result_q;
  assign out_tag    = tag_q;

  // Booth radix-4 recoding: y gets two extension bits and an implicit 0 LSB,
  // giving WIDTH/2+1 digits in {-2..+2}. Negative digits use ~mag with the
  // +1 collected in a separate carry row at the digit's weight.
  always_comb begin
    front = '0;
    trip  = '0;
    mag   = '0;
    neg   = 1'b0;
    x_ext = {{WIDTH{in_x[WIDTH-1] & in_signed}}, in_x};
    y_ext = {{2{in_y[WIDTH-1] & in_signed}}, in_y, 1'b0};
    for (int i = 0; i < NPP; i++) begin
      trip = y_ext[2*i +: 3];
      neg  = trip[2] & ~(trip[1] & trip[0]);
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: mag = x_ext;
        3'b011, 3'b100:                 mag = x_ext << 1;
        default:                        mag = '0;
      endcase
      front.pp[i]   = (neg ? ~mag : mag) << (2*i);
      front.cy[2*i] = neg;
    end
    // msub computes ~(x*y + ~acc), which equals acc - x*y.
    front.inv    = (in_op == 2'b10);
    front.addend = (in_op == 2'b01) ? in_acc :
                   (in_op == 2'b10) ? ~in_acc : '0;
    front.tag    = in_tag;
  end

  generate
    if (STAGES == 1) begin : g_one
      assign fin = reduce(front);
    end else begin : g_multi
      s1_t s1_q;
      cs_t tree;

      // Stage 1: capture partial products ahead of the reduction.
      always_ff @(posedge mul_clk or posedge reset)
        if (reset)    s1_q <= '0;
        else if (adv) s1_q <= front;

      assign tree = reduce(s1_q);

      if (STAGES == 2) begin : g_nomid
        assign fin = tree;
      end else begin : g_mid
        cs_t mid_q [STAGES-2];

        // Middle stages carry the carry-save pair; retiming can move tree
        // levels across them.
        always_ff @(posedge mul_clk or posedge reset)
          if (reset) begin
            for (int k = 0; k < STAGES-2; k++) mid_q[k] <= '0;
          end else if (adv) begin
            mid_q[0] <= tree;
            for (int k = 1; k < STAGES-2; k++) mid_q[k] <= mid_q[k-1];
          end

        assign fin = mid_q[STAGES-3];
      end
    end
  endgenerate

  // Final carry-propagate add, always feeding the output register.
  assign res_d = fin.inv ? ~(fin.s + fin.c + fin.addend)
                         :  (fin.s + fin.c + fin.addend);

  // Output register: held while stalled.
  always_ff @(posedge mul_clk or posedge reset)
    if (reset) begin
      result_q <= '0;
      tag_q    <= '0;
    end else if (adv) begin
      result_q <= res_d;
      tag_q    <= fin.tag;
    end

  // Valid shift register; flush drops everything, even a stalled output.
  always_ff @(posedge mul_clk or posedge reset)
    if (reset)      vld_pipe_q <= '0;
    else if (flush) vld_pipe_q <= '0;
    else if (adv) begin
      vld_pipe_q[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
    end

endmodule
